// File: rtl/issue_pkg.sv
// Shared types and default latencies for the issue scheduler and its CDB slot tracker.
package issue_pkg;

    localparam int LAT_INT_DEF = 1;
    localparam int LAT_MEM_DEF = 2;
    localparam int LAT_MUL_DEF = 4;
    localparam int LAT_DIV_DEF = 7;
    localparam int N_UNITS     = 4;

    typedef enum logic [1:0] {
        UNIT_INT = 2'd0,
        UNIT_MEM = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

    typedef logic [N_UNITS-1:0] grant_t;

endpackage

// File: rtl/cdb_slot_tracker.sv
// Shift register of future CDB reservations; bit k set means the bus is taken k cycles from now.
module cdb_slot_tracker
    import issue_pkg::*;
#(
    parameter int LAT_INT = LAT_INT_DEF,
    parameter int LAT_MEM = LAT_MEM_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int LAT_W   = $clog2(LAT_DIV + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             gnt_vld_i,
    input  logic [LAT_W-1:0] gnt_lat_i,
    output grant_t           slot_free_o,
    output logic             cdb_expect_o
);

    logic [LAT_DIV:0] res_q, res_d;

    // A grant in this cycle broadcasts L cycles out, which is slot L-1 after the shift.
    always_comb begin
        res_d = {1'b0, res_q[LAT_DIV:1]};
        if (gnt_vld_i) begin
            res_d[gnt_lat_i - LAT_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q <= '0;
        end else if (flush_i) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    always_comb begin
        slot_free_o           = '0;
        slot_free_o[UNIT_INT] = ~res_q[LAT_INT];
        slot_free_o[UNIT_MEM] = ~res_q[LAT_MEM];
        slot_free_o[UNIT_MUL] = ~res_q[LAT_MUL];
        slot_free_o[UNIT_DIV] = ~res_q[LAT_DIV];
    end

    assign cdb_expect_o = res_q[0];

endmodule

// File: rtl/issue_scheduler.sv
// Single-grant issue scheduler for int/mem/mul/div stations with CDB slot and divider-busy tracking.
// Define ISSUE_RR_EN for round-robin int/mem arbitration; otherwise mem has fixed priority over int.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int LAT_INT = LAT_INT_DEF,
    parameter int LAT_MEM = LAT_MEM_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic flush,
    input  logic rdy_int,
    input  logic rdy_mem,
    input  logic rdy_mul,
    input  logic rdy_div,
    output logic issue_int,
    output logic issue_mem,
    output logic issue_mul,
    output logic issue_div,
    output logic o_cdb_expect,
    output logic o_div_busy
);

    localparam int LAT_W = $clog2(LAT_DIV + 1);

    grant_t           rdy, slot_free, elig, grant;
    logic             gnt_vld;
    logic [LAT_W-1:0] gnt_lat;
    logic [LAT_W-1:0] div_cnt_q, div_cnt_d;

    assign rdy = {rdy_div, rdy_mul, rdy_mem, rdy_int};

    always_comb begin
        elig           = rdy & slot_free;
        elig[UNIT_DIV] = rdy[UNIT_DIV] & slot_free[UNIT_DIV] & (div_cnt_q == '0);
    end

`ifdef ISSUE_RR_EN
    logic rr_mem_q, rr_mem_d;

    assign rr_mem_d = rr_mem_q ^ (rr_mem_q ? grant[UNIT_MEM] : grant[UNIT_INT]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_mem_q <= 1'b0;
        end else if (flush) begin
            rr_mem_q <= 1'b0;
        end else begin
            rr_mem_q <= rr_mem_d;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (elig[UNIT_DIV]) begin
            grant[UNIT_DIV] = 1'b1;
        end else if (elig[UNIT_MUL]) begin
            grant[UNIT_MUL] = 1'b1;
        end else begin
`ifdef ISSUE_RR_EN
            // A ready but CDB-blocked preferred unit holds the pair so it cannot be starved.
            if (!rr_mem_q) begin
                if (rdy[UNIT_INT]) grant[UNIT_INT] = elig[UNIT_INT];
                else               grant[UNIT_MEM] = elig[UNIT_MEM];
            end else begin
                if (rdy[UNIT_MEM]) grant[UNIT_MEM] = elig[UNIT_MEM];
                else               grant[UNIT_INT] = elig[UNIT_INT];
            end
`else
            if (elig[UNIT_MEM]) grant[UNIT_MEM] = 1'b1;
            else                grant[UNIT_INT] = elig[UNIT_INT];
`endif
        end
        if (flush || !i_rst_n) begin
            grant = '0;
        end
    end

    always_comb begin
        gnt_lat = LAT_W'(LAT_INT);
        if (grant[UNIT_DIV])      gnt_lat = LAT_W'(LAT_DIV);
        else if (grant[UNIT_MUL]) gnt_lat = LAT_W'(LAT_MUL);
        else if (grant[UNIT_MEM]) gnt_lat = LAT_W'(LAT_MEM);
    end

    assign gnt_vld = |grant;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (grant[UNIT_DIV]) begin
            div_cnt_d = LAT_W'(LAT_DIV - 1);
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= '0;
        end else if (flush) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    cdb_slot_tracker #(
        .LAT_INT (LAT_INT),
        .LAT_MEM (LAT_MEM),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .LAT_W   (LAT_W)
    ) u_slots (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .flush_i      (flush),
        .gnt_vld_i    (gnt_vld),
        .gnt_lat_i    (gnt_lat),
        .slot_free_o  (slot_free),
        .cdb_expect_o (o_cdb_expect)
    );

    assign issue_int  = grant[UNIT_INT];
    assign issue_mem  = grant[UNIT_MEM];
    assign issue_mul  = grant[UNIT_MUL];
    assign issue_div  = grant[UNIT_DIV];
    assign o_div_busy = (div_cnt_q != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_issue_scheduler;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic flush = 1'b0;
    logic rdy_int = 1'b0, rdy_mem = 1'b0, rdy_mul = 1'b0, rdy_div = 1'b0;
    logic issue_int, issue_mem, issue_mul, issue_div, o_cdb_expect, o_div_busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [5:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    issue_scheduler dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .flush        (flush),
        .rdy_int      (rdy_int),
        .rdy_mem      (rdy_mem),
        .rdy_mul      (rdy_mul),
        .rdy_div      (rdy_div),
        .issue_int    (issue_int),
        .issue_mem    (issue_mem),
        .issue_mul    (issue_mul),
        .issue_div    (issue_div),
        .o_cdb_expect (o_cdb_expect),
        .o_div_busy   (o_div_busy)
    );

    always #5 i_clk = ~i_clk;

    // in  = {flush, rdy_div, rdy_mul, rdy_mem, rdy_int}
    // exp = {div_busy, cdb_expect, issue_div, issue_mul, issue_mem, issue_int}
    task automatic step(input string tag, input int cyc, input logic [4:0] in,
                        input logic [5:0] exp, input logic rst);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_rst_n = rst;
        {flush, rdy_div, rdy_mul, rdy_mem, rdy_int} = in;
        e.exp = exp;
        e.tag = $sformatf("%s[c%0d]", tag, cyc);
        sb.push_back(e);
    endtask

    task automatic do_reset(input string tag, input logic [4:0] in);
        step(tag, -2, in, 6'b000000, 1'b0);
        step(tag, -1, in, 6'b000000, 1'b0);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o_div_busy, o_cdb_expect, issue_div, issue_mul, issue_mem, issue_int};
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got busy/cdb/div/mul/mem/int=%b expected %b", e.tag, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [5:0] x;

        // Reset with everything ready, then divider wins first cycle after release
        do_reset("t1_reset", 5'b01111);
        step("t1_first", 0, 5'b01111, 6'b001000, 1'b1);
        step("t1_after", 1, 5'b00000, 6'b100000, 1'b1);

        // Back-to-back integer issues
        do_reset("t2_reset", 5'b00000);
        step("t2", 0, 5'b00001, 6'b000001, 1'b1);
        step("t2", 1, 5'b00001, 6'b010001, 1'b1);
        step("t2", 2, 5'b00001, 6'b010001, 1'b1);
        step("t2", 3, 5'b00000, 6'b010000, 1'b1);
        step("t2", 4, 5'b00000, 6'b000000, 1'b1);

        // Multiply reserves slot 4, blocking an int in cycle 3
        do_reset("t3_reset", 5'b00000);
        step("t3", 0, 5'b00100, 6'b000100, 1'b1);
        step("t3", 1, 5'b00000, 6'b000000, 1'b1);
        step("t3", 2, 5'b00000, 6'b000000, 1'b1);
        step("t3", 3, 5'b00001, 6'b000000, 1'b1);
        step("t3", 4, 5'b00001, 6'b010001, 1'b1);
        step("t3", 5, 5'b00000, 6'b010000, 1'b1);
        step("t3", 6, 5'b00000, 6'b000000, 1'b1);

        // Non-pipelined divider held ready
        do_reset("t4_reset", 5'b00000);
        for (int c = 0; c < 15; c++) begin
            if (c == 0)          x = 6'b001000;
            else if (c % 7 == 0) x = 6'b011000;
            else                 x = 6'b100000;
            step("t4", c, 5'b01000, x, 1'b1);
        end
        step("t4", 15, 5'b00000, 6'b100000, 1'b1);

        // Reset lands while the divider is busy: busy must drop at once
        do_reset("t5_reset", 5'b00011);

        // Int and mem both held ready
        for (int c = 0; c < 9; c++) begin
`ifdef ISSUE_RR_EN
            if (c == 0)          x = 6'b000001;
            else if (c % 3 == 1) x = 6'b010010;
            else if (c % 3 == 2) x = 6'b000000;
            else                 x = 6'b010001;
`else
            if (c < 2) x = 6'b000010;
            else       x = 6'b010010;
`endif
            step("t5_pair", c, 5'b00011, x, 1'b1);
        end

        // Flush squashes an in-flight multiply and blocks grants that cycle
        do_reset("t6_reset", 5'b00000);
        step("t6", 0, 5'b00100, 6'b000100, 1'b1);
        step("t6", 1, 5'b00000, 6'b000000, 1'b1);
        step("t6", 2, 5'b10001, 6'b000000, 1'b1);
        step("t6", 3, 5'b00001, 6'b000001, 1'b1);
        step("t6", 4, 5'b00000, 6'b010000, 1'b1);
        step("t6", 5, 5'b00000, 6'b000000, 1'b1);

        // Flush clears divider occupancy so a new divide can issue immediately
        do_reset("t7_reset", 5'b00000);
        step("t7", 0, 5'b01000, 6'b001000, 1'b1);
        step("t7", 1, 5'b00000, 6'b100000, 1'b1);
        step("t7", 2, 5'b11000, 6'b100000, 1'b1);
        step("t7", 3, 5'b01000, 6'b001000, 1'b1);
        step("t7", 4, 5'b00000, 6'b100000, 1'b1);

        @(negedge i_clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
